// File: rtl/freq_pkg.sv
// Shared constants and types for the frequency synthesiser and counter.
// Optional macro FREQ_SYNTH_ROUND_EN widens the dividend by one bit so the
// half-period can be rounded to nearest instead of truncated.
package freq_pkg;

    localparam int unsigned CLK_HZ_DEF = 100_000_000;
    localparam int          FREQ_W     = 16;
    localparam int          DIV_W      = 32;

`ifdef FREQ_SYNTH_ROUND_EN
    localparam int          DVD_W      = DIV_W + 1;
`else
    localparam int          DVD_W      = DIV_W;
`endif

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    // A zero quotient means the request exceeds CLK_HZ/2; run as fast as possible.
    function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] q);
        return (q == '0) ? DIV_W'(1) : q;
    endfunction

endpackage

// File: rtl/freq_synth_if.sv
// Request channel of the frequency synthesiser: a valid/ready frequency port.
interface freq_synth_if;
    logic [freq_pkg::FREQ_W-1:0] freq_in;
    logic                        freq_valid;
    logic                        freq_ready;

    modport master (output freq_in, output freq_valid, input freq_ready);
    modport slave  (input freq_in, input freq_valid, output freq_ready);
endinterface

// File: rtl/freq_synth_seq_divider.sv
// Restoring divider producing one quotient bit per clock.
// A start pulse (re)loads the operands, so a new start abandons any division
// still in progress; done pulses for one cycle when the quotient is valid.
module seq_divider #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem, rem_nx, dvs;
    logic [DVD_W-1:0] quo, quo_nx;
    logic [CNT_W-1:0] cnt;
    logic [DVS_W:0]   rem_sh;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every combinational output is given a default first so no latch is inferred.
        rem_nx = rem;
        quo_nx = {quo[DVD_W-2:0], 1'b0};
        rem_sh = {rem, quo[DVD_W-1]};
        if (rem_sh >= {1'b0, dvs}) begin
            rem_nx    = DVS_W'(rem_sh - {1'b0, dvs});
            quo_nx[0] = 1'b1;
        end else begin
            rem_nx    = rem_sh[DVS_W-1:0];
        end
    end

    // Operand load on start, then DVD_W iteration cycles ending in a done pulse.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                quo  <= dividend;
                dvs  <= divisor;
                cnt  <= CNT_W'(DVD_W);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/freq_synth.sv
// Square-wave synthesiser: turns a frequency request in Hz into a 50%-duty
// output by counting half-periods of CLK_HZ / (2*freq) system clocks.
// Retunes are computed in the background and applied only at a toggle edge.
// FREQ_SYNTH_ROUND_EN selects round-to-nearest half-period (dividend CLK_HZ+freq).
module freq_synth
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
    input  logic         clk,
    input  logic         rst,
    freq_synth_if.slave  bus,
    output logic         sigout,
    output logic         active
);
    state_t             state, state_nx;
    logic [FREQ_W-1:0]  freq_reg;
    logic               div_start, div_busy, div_done;
    logic [DVD_W-1:0]   dividend, quotient;
    logic [DIV_W-1:0]   half_period, pend_half, counter, new_half;
    logic               pend_valid, stop_req;
    logic               accept, accept_nz, accept_zero, result_ok, toggle, stop_now;

    assign bus.freq_ready = (state == IDLE) || (state == RUN && !div_start && !div_busy);
    assign accept      = bus.freq_valid && bus.freq_ready;
    assign accept_nz   = accept && (bus.freq_in != '0);
    assign accept_zero = accept && (bus.freq_in == '0);
    // A done seen while a restart is being issued belongs to an abandoned division.
    assign result_ok   = div_done && !div_start;
    assign new_half    = clamp_half(quotient[DIV_W-1:0]);
    assign toggle      = (state == RUN) && (counter == half_period - DIV_W'(1));
    // Stop at a falling toggle, or at once when the output is already low.
    assign stop_now    = (state == RUN) && ((accept_zero && !sigout) ||
                                            ((stop_req || accept_zero) && toggle && sigout));

`ifdef FREQ_SYNTH_ROUND_EN
    assign dividend = DVD_W'(CLK_HZ) + DVD_W'(freq_reg);
`else
    assign dividend = DVD_W'(CLK_HZ);
`endif

    seq_divider #(.DVD_W(DVD_W), .DVS_W(FREQ_W + 1)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  ({freq_reg, 1'b0}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_nz) state_nx = DIV;
            DIV:     if (result_ok) state_nx = RUN;
            RUN:     if (stop_now)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, period bookkeeping and output waveform.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_reg    <= '0;
            div_start   <= 1'b0;
            half_period <= '0;
            pend_half   <= '0;
            pend_valid  <= 1'b0;
            stop_req    <= 1'b0;
            counter     <= '0;
            sigout      <= 1'b0;
            active      <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    sigout     <= 1'b0;
                    active     <= 1'b0;
                    counter    <= '0;
                    pend_valid <= 1'b0;
                    stop_req   <= 1'b0;
                    if (accept_nz) begin
                        freq_reg  <= bus.freq_in;
                        div_start <= 1'b1;
                    end
                end
                DIV: begin
                    if (result_ok) begin
                        half_period <= new_half;
                        counter     <= '0;
                        sigout      <= 1'b1;
                        active      <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop_now) begin
                        sigout     <= 1'b0;
                        active     <= 1'b0;
                        counter    <= '0;
                        pend_valid <= 1'b0;
                        stop_req   <= 1'b0;
                    end else begin
                        if (toggle) begin
                            sigout  <= ~sigout;
                            counter <= '0;
                            if (pend_valid) begin
                                half_period <= pend_half;
                                pend_valid  <= 1'b0;
                            end
                        end else begin
                            counter <= counter + DIV_W'(1);
                        end
                        if (result_ok) begin
                            pend_half  <= new_half;
                            pend_valid <= 1'b1;
                        end
                        if (accept_nz) begin
                            freq_reg  <= bus.freq_in;
                            div_start <= 1'b1;
                            stop_req  <= 1'b0;
                        end else if (accept_zero) begin
                            stop_req  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_synth.sv
// Self-checking bench for freq_synth at CLK_HZ=1000: edge times of sigout are
// compared against half-periods computed directly from the frequency request.
module tb_freq_synth;
    import freq_pkg::*;

    localparam int unsigned SIM_HZ = 1000;
`ifdef FREQ_SYNTH_ROUND_EN
    localparam int LAT = 35;
`else
    localparam int LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sigout, active;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    freq_synth_if bus();

    freq_synth #(.CLK_HZ(SIM_HZ)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .sigout (sigout),
        .active (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_half(input int f);
        int q;
`ifdef FREQ_SYNTH_ROUND_EN
        q = (int'(SIM_HZ) + f) / (2 * f);
`else
        q = int'(SIM_HZ) / (2 * f);
`endif
        return (q == 0) ? 1 : q;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a request once ready; acc is the cycle index of the accepting edge.
    task automatic send(input int f, output int acc);
        int waited = 0;
        while (!bus.freq_ready && waited < 200) begin
            tick(1);
            waited++;
        end
        if (!bus.freq_ready) check("ready_wait", 0, 1);
        bus.freq_in    = FREQ_W'(f);
        bus.freq_valid = 1'b1;
        tick(1);
        acc            = cyc;
        bus.freq_valid = 1'b0;
        bus.freq_in    = '0;
    endtask

    // Next change of sigout within limit cycles; at = -1 on timeout.
    task automatic wait_edge(input int limit, output int at, output logic lvl);
        logic prev = sigout;
        at  = -1;
        lvl = sigout;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (sigout !== prev) begin
                at  = cyc;
                lvl = sigout;
                return;
            end
        end
    endtask

    task automatic check_intervals(input string tag, input int start, input int n,
                                   input int half, output int last, output int min_iv);
        int   e;
        logic lvl;
        last   = start;
        min_iv = 1 << 30;
        for (int i = 0; i < n; i++) begin
            wait_edge(half * 3 + 50, e, lvl);
            check(tag, e - last, half);
            if (e < 0) return;
            if (e - last < min_iv) min_iv = e - last;
            last = e;
        end
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check({tag, "_sigout"}, sigout, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_ready"},  bus.freq_ready, 1);
    endtask

    // Start from IDLE and check the first-rise latency; returns the rise cycle.
    task automatic start_run(input string tag, input int f, output int rise);
        int   acc;
        logic lvl;
        send(f, acc);
        wait_edge(LAT + 20, rise, lvl);
        check({tag, "_lat"}, rise - acc, LAT);
        check({tag, "_lvl"}, lvl, 1);
    endtask

    initial begin
        int   acc, rise, e, last, min_iv, low_cnt, f0, f1;
        logic lvl;

        bus.freq_in    = '0;
        bus.freq_valid = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_sigout", sigout, 0);
        check("rst_active", active, 0);
        check("rst_ready",  bus.freq_ready, 1);

        // freq=1: latency, ready low during the division, 500/500 waveform.
        send(1, acc);
        low_cnt = (bus.freq_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 31; i++) begin
            tick(1);
            if (bus.freq_ready == 1'b0) low_cnt++;
        end
        check("f1_ready_low", low_cnt, 32);
        wait_edge(LAT + 20, rise, lvl);
        check("f1_lat", rise - acc, LAT);
        check("f1_active", active, 1);
        check_intervals("f1_iv", rise, 2, model_half(1), last, min_iv);

        // Retune to 5 Hz mid high phase: current 500-clock phase is kept.
        tick(100);
        send(5, acc);
        wait_edge(700, e, lvl);
        check("rt_keep_old", e - last, model_half(1));
        check("rt_keep_lvl", lvl, 0);
        check_intervals("rt_iv", e, 4, model_half(5), last, min_iv);
        check("rt_min_pulse", min_iv, model_half(5));

        // Stop during a high phase: waits for the scheduled falling toggle.
        if (sigout == 1'b0) wait_edge(300, last, lvl);
        tick(10);
        send(0, acc);
        wait_edge(300, e, lvl);
        check("stop_fall_at", e - last, model_half(5));
        check("stop_lvl", lvl, 0);
        check("stop_active", active, 0);
        wait_edge(300, e, lvl);
        check("stop_quiet", e, -1);
        send(0, acc);
        wait_edge(100, e, lvl);
        check("idle_zero_quiet", e, -1);
        check("idle_zero_active", active, 0);
        check("idle_zero_ready", bus.freq_ready, 1);

        // Stop while low: immediate.
        start_run("lowstop", 5, rise);
        wait_edge(300, e, lvl);
        tick(5);
        send(0, acc);
        check("lowstop_active", active, 0);
        check("lowstop_sigout", sigout, 0);
        wait_edge(300, e, lvl);
        check("lowstop_quiet", e, -1);

        // freq=3 from fresh reset: three exact full periods.
        pulse_rst("r3");
        start_run("f3", 3, rise);
        check_intervals("f3_iv", rise, 6, model_half(3), last, min_iv);

        // freq=600: clamped to a one-clock half-period.
        pulse_rst("r600");
        start_run("f600", 600, rise);
        check_intervals("f600_iv", rise, 8, model_half(600), last, min_iv);

        // Reset in DIV, then freq=2 behaves as fresh.
        pulse_rst("r_pre");
        send(7, acc);
        tick(10);
        pulse_rst("r_div");
        start_run("f2a", 2, rise);
        check_intervals("f2a_iv", rise, 2, model_half(2), last, min_iv);

        // Reset in RUN, then freq=2 again.
        tick(20);
        pulse_rst("r_run");
        wait_edge(50, e, lvl);
        check("r_run_quiet", e, -1);
        start_run("f2b", 2, rise);
        check_intervals("f2b_iv", rise, 2, model_half(2), last, min_iv);

        // Randomised start/retune pairs against the arithmetic model.
        for (int it = 0; it < 4; it++) begin
            f0 = int'($urandom_range(1, 8));
            f1 = int'($urandom_range(1, 600));
            pulse_rst("rnd_rst");
            start_run("rnd_start", f0, rise);
            check_intervals("rnd_iv0", rise, 2, model_half(f0), last, min_iv);
            send(f1, acc);
            wait_edge(model_half(f0) * 3 + 50, e, lvl);
            check("rnd_old", e - last, model_half(f0));
            check_intervals("rnd_iv1", e, 3, model_half(f1), last, min_iv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
